player_input_sampler: RTL and testbench
=======================================

// Module: player_input_sampler
// PURPOSE
//   Front end of the player_buttons interface: turns raw board button pins into the per-frame
//   player_buttons vector consumed by player_next_state_calc.
//   - Synchronises and debounces each button pin.
//   - Cancels contradictory walk inputs.
//   - Presents one stable snapshot per frame_clk rising edge, so the state logic sees a
//     constant vector for the whole frame.
//   - One instance per player.
// PARAMETERS
//   INPUT_DEPTH      5       button count; bit positions K/B/G/WB/WF_BUTTON from params.vh
//   DEBOUNCE_CYCLES  250000  consecutive disagreeing sys_clk cycles before a button changes (5 ms @ 50 MHz)
//   SYNC_STAGES      2       flip-flop synchroniser depth for raw_buttons and frame_clk (>=2)
//   RAW_ACTIVE_LOW   1       1: a pin reads 0 when pressed (board KEYs); 0: a pin reads 1 when pressed
// PORTS
//   sys_clk          in   1            system clock; the only clock
//   sys_rst_n        in   1            asynchronous, active-low reset
//   raw_buttons      in   INPUT_DEPTH  asynchronous button pins, polarity per RAW_ACTIVE_LOW
//   frame_clk        in   1            frame clock, asynchronous to sys_clk; used as data only
//   player_buttons   out  INPUT_DEPTH  per-frame snapshot, 1 = pressed
//   buttons_valid    out  1            1-cycle pulse; player_buttons updated this cycle
//   frame_strobe     out  1            1-cycle pulse on each detected frame_clk rising edge
// BEHAVIOUR
//   - Clocking/reset: one clock (sys_clk); reset is asynchronous and active-low (sys_rst_n).
//   - Reset state: all outputs 0; synchroniser flops, debounced state, counters and press latches cleared.
//     Debounced state resets to "released" regardless of RAW_ACTIVE_LOW.
//   - Sync: each raw bit passes SYNC_STAGES flops, then is inverted if RAW_ACTIVE_LOW, giving pressed_sync.
//   - Debounce (per bit, independent):
//     - stable holds the debounced value; cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
//     - When pressed_sync == stable, cnt <= 0.
//     - Otherwise cnt increments. In the cycle cnt == DEBOUNCE_CYCLES-1, stable <= pressed_sync and cnt <= 0.
//     - Any bounce back to agreement clears cnt. cnt never wraps.
//     - Latency from pin change to stable: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
//   - Frame edge: frame_clk passes SYNC_STAGES flops plus one history flop.
//     - frame_strobe = synced & ~history, so it is exactly one cycle per rising edge.
//     - frame_clk held high or low produces no further strobes.
//   - Snapshot: in the cycle after frame_strobe, player_buttons <= filtered and buttons_valid = 1 for 1 cycle.
//     - player_buttons holds its value between snapshots.
//   - Walk cancel: filtered = source with WF and WB both forced to 0 when both are 1 in source.
//     - All other bits pass unchanged.
//     - Kick/block/grab priority is not resolved here; gen_state_buttons resolves it.
//   - Simultaneous events: a stable change in the same cycle as frame_strobe is NOT in that snapshot.
//     The snapshot samples the value registered at the strobe cycle.
//   - Reset mid-operation: all state clears asynchronously. The first snapshot after release needs a new rising edge.
// CONFIGURATION
//   - Macro BUTTON_PRESS_LATCH_EN.
//   - Defined:
//     - Each bit has a sticky press latch, set on a stable 0->1 transition.
//     - source = stable | latch.
//     - Latches clear in the snapshot cycle. A press set in that same cycle survives into the next frame.
//     - Taps shorter than one frame are delivered exactly once.
//   - Undefined:
//     - source = stable; taps released before the frame edge are lost.
//     - No latch flops are instantiated.
// STRUCTURE
//   - params.vh (shared) holds INPUT_DEPTH and the K/B/G/WB/WF_BUTTON indices. No new constants go in the
//     block. DEBOUNCE default is a localparam derived from a SYS_CLK_HZ define if present.
//   - Sub-module button_debouncer (sync + counter + stable for one bit, parameters DEBOUNCE_CYCLES and
//     SYNC_STAGES). Instantiated INPUT_DEPTH times in a generate loop.
//   - Frame-edge detect, walk cancel, press latch and snapshot registers live in the top.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RAW_ACTIVE_LOW=1)
//   - Reset:
//     - Assert sys_rst_n=0 mid-run with buttons pressed -> outputs 0 immediately (async).
//     - Release and pulse frame_clk -> player_buttons=5'b0.
//   - Debounce:
//     - Hold K pin low 6 cycles, then frame edge -> player_buttons[K_BUTTON]=1.
//     - Glitch K low 3 cycles, high 1, low 3 -> stable never sets.
//   - Frame strobe:
//     - frame_clk high for 100 cycles -> exactly one frame_strobe.
//     - buttons_valid one cycle after it; player_buttons constant between edges.
//   - Walk cancel:
//     - WF and WB both held -> snapshot has both 0.
//     - WF alone -> WF=1.
//     - G+WF+WB -> only G=1.
//   - Press latch: 20-cycle K tap between two frame edges.
//     - With BUTTON_PRESS_LATCH_EN -> K=1 in the next snapshot only, then 0.
//     - Without it -> K=0.
//   - Edge coincidence: stable K rises in the frame_strobe cycle.
//     - Snapshot N has K=0, snapshot N+1 has K=1, in both configurations.

Source files
------------

// File: rtl/player_input_sampler_pkg.sv
// ==========================================================================
// player_input_sampler_pkg : shared button indices, widths and walk-cancel rule
// Rev 1.0
// ==========================================================================
`default_nettype none

`ifndef SYS_CLK_HZ
`define SYS_CLK_HZ 50000000
`endif

package player_input_sampler_pkg;

  localparam int INPUT_DEPTH = 5;
  localparam int K_BUTTON    = 0;
  localparam int B_BUTTON    = 1;
  localparam int G_BUTTON    = 2;
  localparam int WB_BUTTON   = 3;
  localparam int WF_BUTTON   = 4;

  // 5 ms debounce window at the board clock rate
  localparam int DEBOUNCE_DEFAULT = `SYS_CLK_HZ / 200;

  typedef logic [INPUT_DEPTH-1:0] buttons_t;

  function automatic buttons_t walk_cancel(input buttons_t src);
    buttons_t res;
    res = src;
    if (src[WF_BUTTON] && src[WB_BUTTON]) begin
      res[WF_BUTTON] = 1'b0;
      res[WB_BUTTON] = 1'b0;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ==========================================================================
// button_debouncer : synchroniser + consecutive-disagreement counter for one pin
// Option: BUTTON_PRESS_LATCH_EN adds rise_o. Rev 1.0
// ==========================================================================
`default_nettype none

module button_debouncer
  import player_input_sampler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pressed_async_i,
`ifdef BUTTON_PRESS_LATCH_EN
  output logic rise_o,
`endif
  output logic stable_o
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [c_CNT_W-1:0]     cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   w_pressed_sync;

  assign w_pressed_sync = sync_q[SYNC_STAGES-1];

  // Flip on the last disagreeing cycle; any agreement restarts the count
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (w_pressed_sync != stable_q) begin
      if (cnt_q == c_CNT_LAST) begin
        stable_d = w_pressed_sync;
      end else begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pressed_async_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`ifdef BUTTON_PRESS_LATCH_EN
  assign rise_o = stable_d & ~stable_q;
`endif

endmodule

`default_nettype wire

// File: rtl/player_input_sampler.sv
// ==========================================================================
// player_input_sampler : per-frame debounced button snapshot for one player
// Option: BUTTON_PRESS_LATCH_EN (sticky press latch per button). Rev 1.0
// ==========================================================================
`default_nettype none

module player_input_sampler
  import player_input_sampler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [INPUT_DEPTH-1:0] raw_buttons,
  input  logic                   frame_clk,
  output logic [INPUT_DEPTH-1:0] player_buttons,
  output logic                   buttons_valid,
  output logic                   frame_strobe
);

  localparam logic c_PIN_INVERT = (RAW_ACTIVE_LOW != 0);

  buttons_t               w_pressed_async, w_stable, w_source, w_filtered;
  logic [SYNC_STAGES-1:0] frame_sync_q;
  logic                   frame_hist_q;
  logic                   w_frame_strobe;
  buttons_t               buttons_q, buttons_d;
  logic                   valid_q, valid_d;
`ifdef BUTTON_PRESS_LATCH_EN
  buttons_t               w_rise, latch_q, latch_d;
`endif

  // Inverting ahead of the synchroniser lets reset mean "released" for either polarity
  assign w_pressed_async = raw_buttons ^ {INPUT_DEPTH{c_PIN_INVERT}};

  generate
    for (genvar i = 0; i < INPUT_DEPTH; i++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_debouncer (
        .clk_i           (sys_clk),
        .rst_ni          (sys_rst_n),
        .pressed_async_i (w_pressed_async[i]),
`ifdef BUTTON_PRESS_LATCH_EN
        .rise_o          (w_rise[i]),
`endif
        .stable_o        (w_stable[i])
      );
    end
  endgenerate

  assign w_frame_strobe = frame_sync_q[SYNC_STAGES-1] & ~frame_hist_q;

`ifdef BUTTON_PRESS_LATCH_EN
  // A rise in the snapshot cycle is not in this snapshot, so it must survive the clear
  always_comb begin
    latch_d = w_frame_strobe ? '0 : latch_q;
    latch_d = latch_d | w_rise;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign w_source = w_stable | latch_q;
`else
  assign w_source = w_stable;
`endif

  assign w_filtered = walk_cancel(w_source);

  always_comb begin
    buttons_d = buttons_q;
    valid_d   = w_frame_strobe;
    if (w_frame_strobe) begin
      buttons_d = w_filtered;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_sync_q <= '0;
      frame_hist_q <= 1'b0;
      buttons_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], frame_clk};
      frame_hist_q <= frame_sync_q[SYNC_STAGES-1];
      buttons_q    <= buttons_d;
      valid_q      <= valid_d;
    end
  end

  assign player_buttons = buttons_q;
  assign buttons_valid  = valid_q;
  assign frame_strobe   = w_frame_strobe;

endmodule

`default_nettype wire

// File: tb/tb_player_input_sampler.sv
// ==========================================================================
// tb_player_input_sampler : directed stimulus, cycle model and literal checks
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_player_input_sampler;
  import player_input_sampler_pkg::*;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
`ifdef BUTTON_PRESS_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic                   sys_clk   = 1'b0;
  logic                   sys_rst_n = 1'b0;
  logic [INPUT_DEPTH-1:0] raw_buttons;
  logic                   frame_clk;
  logic [INPUT_DEPTH-1:0] player_buttons;
  logic                   buttons_valid;
  logic                   frame_strobe;

  int checks     = 0;
  int errors     = 0;
  int strobe_cnt = 0;
  int valid_cnt  = 0;

  always #5 sys_clk = ~sys_clk;

  player_input_sampler #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .RAW_ACTIVE_LOW  (1)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .raw_buttons    (raw_buttons),
    .frame_clk      (frame_clk),
    .player_buttons (player_buttons),
    .buttons_valid  (buttons_valid),
    .frame_strobe   (frame_strobe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [INPUT_DEPTH-1:0] bmask(input int idx);
    logic [INPUT_DEPTH-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // ---------------- behavioural model ----------------
  logic [INPUT_DEPTH-1:0] m_pin_dly [SYNC];
  logic                   m_frm_dly [SYNC+1];
  logic [INPUT_DEPTH-1:0] m_stable, m_pend, m_pb;
  int                     m_run [INPUT_DEPTH];
  logic                   m_valid, m_strobe;

  function automatic logic [INPUT_DEPTH-1:0] walk_rule(input logic [INPUT_DEPTH-1:0] s);
    logic [INPUT_DEPTH-1:0] r;
    r = s;
    if (s[WF_BUTTON] && s[WB_BUTTON]) begin
      r[WF_BUTTON] = 1'b0;
      r[WB_BUTTON] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pin_dly[i] = '0;
    for (int i = 0; i <= SYNC; i++) m_frm_dly[i] = 1'b0;
    for (int b = 0; b < INPUT_DEPTH; b++) m_run[b] = 0;
    m_stable = '0; m_pend = '0; m_pb = '0; m_valid = 1'b0; m_strobe = 1'b0;
  endtask

  task automatic model_step();
    logic [INPUT_DEPTH-1:0] ps, prev, rose, src;
    logic                   snap;
    ps   = m_pin_dly[SYNC-1];
    snap = m_strobe;
    prev = m_stable;
    for (int b = 0; b < INPUT_DEPTH; b++) begin
      if (ps[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_stable[b] = ps[b];
          m_run[b]    = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    rose = m_stable & ~prev;
    src  = LATCH ? (prev | m_pend) : prev;
    if (snap) m_pb = walk_rule(src);
    if (LATCH) m_pend = snap ? rose : (m_pend | rose);
    m_valid = snap;
    for (int i = SYNC - 1; i > 0; i--) m_pin_dly[i] = m_pin_dly[i-1];
    m_pin_dly[0] = ~raw_buttons;
    for (int i = SYNC; i > 0; i--) m_frm_dly[i] = m_frm_dly[i-1];
    m_frm_dly[0] = frame_clk;
    m_strobe = m_frm_dly[SYNC-1] & ~m_frm_dly[SYNC];
  endtask

  initial begin
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else            model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge sys_clk);
      check("model_player_buttons", 32'(player_buttons), 32'(m_pb));
      check("model_buttons_valid",  32'(buttons_valid),  32'(m_valid));
      check("model_frame_strobe",   32'(frame_strobe),   32'(m_strobe));
      if (frame_strobe)  strobe_cnt++;
      if (buttons_valid) valid_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic press(input logic [INPUT_DEPTH-1:0] mask);
    raw_buttons = ~mask;
  endtask

  task automatic frame_snap(output logic [INPUT_DEPTH-1:0] pb);
    bit seen;
    seen      = 1'b0;
    pb        = '0;
    frame_clk = 1'b1;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge sys_clk);
      if (buttons_valid) begin
        seen = 1'b1;
        pb   = player_buttons;
      end
    end
    check("snapshot_arrived", 32'(seen), 32'd1);
    tick(4);
    frame_clk = 1'b0;
    tick(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before t=100000");
    $fatal(1);
  end

  initial begin
    logic [INPUT_DEPTH-1:0] pb;
    int s0, v0;
    raw_buttons = '1;
    frame_clk   = 1'b0;
    sys_rst_n   = 1'b0;
    tick(3);
    check("reset_player_buttons", 32'(player_buttons), 32'd0);
    check("reset_buttons_valid",  32'(buttons_valid),  32'd0);
    check("reset_frame_strobe",   32'(frame_strobe),   32'd0);
    sys_rst_n = 1'b1;
    tick(4);
    frame_snap(pb);
    check("snap_after_reset", 32'(pb), 32'd0);

    // Debounce: held press, release, then a bouncing press that never settles
    press(bmask(K_BUTTON)); tick(8);
    frame_snap(pb);
    check("k_held", 32'(pb), 32'b00001);
    press('0); tick(8);
    frame_snap(pb);
    check("k_released", 32'(pb), 32'd0);
    press(bmask(K_BUTTON)); tick(3);
    press('0);              tick(1);
    press(bmask(K_BUTTON)); tick(3);
    press('0);              tick(10);
    frame_snap(pb);
    check("k_glitch", 32'(pb), 32'd0);

    // Frame held high / low for 100 cycles
    s0 = strobe_cnt; v0 = valid_cnt;
    frame_clk = 1'b1; tick(100);
    check("strobes_high_100", 32'(strobe_cnt - s0), 32'd1);
    check("valids_high_100",  32'(valid_cnt - v0),  32'd1);
    s0 = strobe_cnt;
    frame_clk = 1'b0; tick(100);
    check("strobes_low_100", 32'(strobe_cnt - s0), 32'd0);

    // Walk cancel
    press(bmask(WF_BUTTON) | bmask(WB_BUTTON)); tick(8);
    frame_snap(pb);
    check("wf_wb_cancel", 32'(pb), 32'd0);
    press(bmask(WF_BUTTON)); tick(8);
    frame_snap(pb);
    check("wf_alone", 32'(pb), 32'b10000);
    press(bmask(G_BUTTON) | bmask(WF_BUTTON) | bmask(WB_BUTTON)); tick(8);
    frame_snap(pb);
    check("g_wf_wb", 32'(pb), 32'b00100);
    press(bmask(B_BUTTON)); tick(8);
    frame_snap(pb);
    check("b_alone", 32'(pb), 32'b00010);
    press('0); tick(8);
    frame_snap(pb);
    check("all_released", 32'(pb), 32'd0);

    // Short tap between two frame edges
    press(bmask(K_BUTTON)); tick(20);
    press('0);              tick(10);
    frame_snap(pb);
    check("tap_first_snap", 32'(pb), LATCH ? 32'b00001 : 32'd0);
    frame_snap(pb);
    check("tap_second_snap", 32'(pb), 32'd0);

    // Stable K rises at the edge that ends the strobe cycle
    press(bmask(K_BUTTON)); tick(3);
    frame_snap(pb);
    check("coincide_snap_n", 32'(pb), 32'd0);
    frame_snap(pb);
    check("coincide_snap_n1", 32'(pb), 32'b00001);

    // Asynchronous reset with buttons pressed
    press(bmask(K_BUTTON) | bmask(G_BUTTON)); tick(8);
    frame_snap(pb);
    check("pre_reset_snap", 32'(pb), 32'b00101);
    #4;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset_player_buttons", 32'(player_buttons), 32'd0);
    check("async_reset_buttons_valid",  32'(buttons_valid),  32'd0);
    press('0);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    tick(8);
    frame_snap(pb);
    check("post_reset_snap", 32'(pb), 32'd0);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
